// File: rtl/rdtype_checker.sv
// rdtype_checker: response checker for a D-type flip-flop with an active-low
// asynchronous reset. It samples D, Q, nQ and nRstObs on each rising Clock edge
// and compares Q against the expected D-type behaviour. A single-cycle history
// of D and nRstObs supplies the expected value. Outputs are a per-sample Error
// pulse, a sticky Fail flag and saturating error and check counters.
module rdtype_checker #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 nRstObs,
  input  logic                 D,
  input  logic                 Q,
  input  logic                 nQ,
  output logic                 Error,
  output logic                 Fail,
  output logic [CNT_WIDTH-1:0] ErrCount,
  output logic [CNT_WIDTH-1:0] CheckCount,
  output logic [1:0]           State
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PRIME = 2'b01,
    ST_RUN   = 2'b10,
    ST_FAIL  = 2'b11
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t                 state_q, state_d;
  logic                   dh_q, dh_d;
  logic                   rh_q, rh_d;
  logic                   error_q, error_d;
  logic                   fail_q, fail_d;
  logic [CNT_WIDTH-1:0]   err_count_q, err_count_d;
  logic [CNT_WIDTH-1:0]   check_count_q, check_count_d;

  logic exp_q;
  logic comp_bad;
  logic full_bad;
  logic checking;
  logic mismatch;

  // Compute the expected response, classify this sample, and derive all next-state values.
  always_comb begin
    // An async reset that is low now, or was low at the previous edge, keeps the flop at 0.
    exp_q    = (nRstObs & rh_q) ? dh_q : 1'b0;
    comp_bad = (nQ == Q);
    full_bad = (Q != exp_q) | comp_bad;
    checking = (state_q != ST_IDLE);

    mismatch = 1'b0;
    state_d  = state_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_PRIME;
      end
      ST_PRIME: begin
        // History does not hold a real previous sample yet, so only the complement is checked.
        mismatch = comp_bad;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        mismatch = full_bad;
        if (full_bad) begin
          state_d = ST_FAIL;
        end
      end
      ST_FAIL: begin
        mismatch = full_bad;
        state_d  = ST_FAIL;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    dh_d    = D;
    rh_d    = nRstObs;
    error_d = mismatch;
    fail_d  = (state_d == ST_FAIL);

    check_count_d = check_count_q;
    if (checking && (check_count_q != CNT_MAX)) begin
      check_count_d = check_count_q + CNT_ONE;
    end

    err_count_d = err_count_q;
    if (mismatch && (err_count_q != CNT_MAX)) begin
      err_count_d = err_count_q + CNT_ONE;
    end
  end

  // Register the FSM state, the history and the outputs. Reset clears everything synchronously.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      dh_q          <= 1'b0;
      rh_q          <= 1'b0;
      error_q       <= 1'b0;
      fail_q        <= 1'b0;
      err_count_q   <= '0;
      check_count_q <= '0;
    end else begin
      state_q       <= state_d;
      dh_q          <= dh_d;
      rh_q          <= rh_d;
      error_q       <= error_d;
      fail_q        <= fail_d;
      err_count_q   <= err_count_d;
      check_count_q <= check_count_d;
    end
  end

  assign Error      = error_q;
  assign Fail       = fail_q;
  assign ErrCount   = err_count_q;
  assign CheckCount = check_count_q;
  assign State      = state_q;

endmodule

// File: tb/tb_rdtype_checker.sv
// Testbench for rdtype_checker: a reference reset D-flop drives the main
// checker, with optional Q/nQ fault overrides. A second CNT_WIDTH=2 instance
// watches a stuck-at-1 Q for the saturation tests.
module tb_rdtype_checker;

  logic       clk;
  logic       reset;
  logic       rst_n;
  logic       d;
  logic       q_flop;
  logic       q_force;
  logic       q_force_val;
  logic       nq_eq;
  logic       q_drv;
  logic       nq_drv;
  logic       error;
  logic       fail;
  logic [7:0] err_count;
  logic [7:0] check_count;
  logic [1:0] state;

  logic       sat_reset;
  logic       sat_error;
  logic       sat_fail;
  logic [1:0] sat_err_count;
  logic [1:0] sat_check_count;
  logic [1:0] sat_state;

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference D flop with active-low async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_flop <= 1'b0;
    else        q_flop <= d;
  end

  assign q_drv  = q_force ? q_force_val : q_flop;
  assign nq_drv = nq_eq ? q_drv : ~q_drv;

  rdtype_checker #(.CNT_WIDTH(8)) u_dut (
    .Clock(clk), .Reset(reset), .nRstObs(rst_n), .D(d), .Q(q_drv), .nQ(nq_drv),
    .Error(error), .Fail(fail), .ErrCount(err_count), .CheckCount(check_count), .State(state)
  );

  rdtype_checker #(.CNT_WIDTH(2)) u_sat (
    .Clock(clk), .Reset(sat_reset), .nRstObs(1'b1), .D(1'b0), .Q(1'b1), .nQ(1'b0),
    .Error(sat_error), .Fail(sat_fail), .ErrCount(sat_err_count),
    .CheckCount(sat_check_count), .State(sat_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    $display("[%0t] st=%0d err=%0b fail=%0b ec=%0d cc=%0d | sat st=%0d err=%0b ec=%0d cc=%0d",
             $time, state, error, fail, err_count, check_count,
             sat_state, sat_error, sat_err_count, sat_check_count);
  endtask

  task automatic test_reset();
    reset = 1'b1; rst_n = 1'b0; d = 1'b0;
    repeat (3) tick();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %0b want 0", error); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL reset_fail: got %0b want 0", fail); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_ec: got %0d want 0", err_count); end
    checks++; if (check_count !== 8'd0) begin errors++; $display("FAIL reset_cc: got %0d want 0", check_count); end
    reset = 1'b0;
    tick();
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL prime_state: got %0d want 1", state); end
    checks++; if (check_count !== 8'd0) begin errors++; $display("FAIL prime_cc: got %0d want 0", check_count); end
    tick();
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL run_state: got %0d want 2", state); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL held_rst_error[%0d]: got %0b want 0", i, error); end
    end
    checks++; if (check_count !== 8'd5) begin errors++; $display("FAIL run_cc: got %0d want 5", check_count); end
  endtask

  task automatic test_pattern();
    logic [4:0] pat;
    pat = 5'b01101; // applied LSB first: 1,0,1,1,0
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = pat[i];
      tick();
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL pattern_error[%0d]: got %0b want 0", i, error); end
    end
    tick();
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL pattern_tail_error: got %0b want 0", error); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL pattern_ec: got %0d want 0", err_count); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL pattern_state: got %0d want 2", state); end
    checks++; if (check_count !== 8'd11) begin errors++; $display("FAIL pattern_cc: got %0d want 11", check_count); end
  endtask

  task automatic test_complement();
    nq_eq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL comp_error[%0d]: got %0b want 1", i, error); end
      checks++; if (err_count !== 8'(i + 1)) begin errors++; $display("FAIL comp_ec[%0d]: got %0d want %0d", i, err_count, i + 1); end
      checks++; if (fail !== 1'b1) begin errors++; $display("FAIL comp_fail[%0d]: got %0b want 1", i, fail); end
      checks++; if (state !== 2'b11) begin errors++; $display("FAIL comp_state[%0d]: got %0d want 3", i, state); end
    end
    nq_eq = 1'b0;
    tick();
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL comp_after_error: got %0b want 0", error); end
    checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL comp_after_ec: got %0d want 3", err_count); end
  endtask

  task automatic test_q_fault();
    // d is 0 and the flop holds 0, so forcing Q=1 for one sample is a mismatch.
    q_force = 1'b1; q_force_val = 1'b1;
    tick();
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL qfault_error: got %0b want 1", error); end
    checks++; if (err_count !== 8'd4) begin errors++; $display("FAIL qfault_ec: got %0d want 4", err_count); end
    q_force = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL qfault_after_error[%0d]: got %0b want 0", i, error); end
      checks++; if (err_count !== 8'd4) begin errors++; $display("FAIL qfault_after_ec[%0d]: got %0d want 4", i, err_count); end
      checks++; if (fail !== 1'b1) begin errors++; $display("FAIL qfault_sticky[%0d]: got %0b want 1", i, fail); end
    end
  endtask

  task automatic test_reset_in_fail();
    reset = 1'b1;
    tick();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL rif_state: got %0d want 0", state); end
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL rif_fail: got %0b want 0", fail); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rif_ec: got %0d want 0", err_count); end
    checks++; if (check_count !== 8'd0) begin errors++; $display("FAIL rif_cc: got %0d want 0", check_count); end
    reset = 1'b0;
    tick();
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL rif_prime: got %0d want 1", state); end
    tick();
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL rif_run: got %0d want 2", state); end
    checks++; if (check_count !== 8'd1) begin errors++; $display("FAIL rif_cc1: got %0d want 1", check_count); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rif_error: got %0b want 0", error); end
  endtask

  task automatic test_saturation();
    int exp_cc [8] = '{0, 1, 2, 3, 3, 3, 3, 3};
    int exp_ec [8] = '{0, 0, 1, 2, 3, 3, 3, 3};
    sat_reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (sat_check_count !== 2'(exp_cc[i])) begin errors++; $display("FAIL sat_cc[%0d]: got %0d want %0d", i, sat_check_count, exp_cc[i]); end
      checks++; if (sat_err_count !== 2'(exp_ec[i])) begin errors++; $display("FAIL sat_ec[%0d]: got %0d want %0d", i, sat_err_count, exp_ec[i]); end
      if (i >= 2) begin
        checks++; if (sat_error !== 1'b1) begin errors++; $display("FAIL sat_error[%0d]: got %0b want 1", i, sat_error); end
        checks++; if (sat_fail !== 1'b1) begin errors++; $display("FAIL sat_fail[%0d]: got %0b want 1", i, sat_fail); end
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; sat_reset = 1'b1; rst_n = 1'b0; d = 1'b0;
    q_force = 1'b0; q_force_val = 1'b0; nq_eq = 1'b0;
    test_reset();
    test_pattern();
    test_complement();
    test_q_fault();
    test_reset_in_fail();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
